// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and the round-robin search helper for the RAM port arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    localparam int STAT_WIDTH = 16;
    localparam int MAX_PORTS  = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Search starts one past the last owner and wraps, so the last owner is tried last.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input int unsigned          last,
                                         input int unsigned          num);
        rr_pick_t    res;
        int unsigned cand;
        res = '0;
        for (int unsigned d = 1; d <= MAX_PORTS; d++) begin
            cand = (last + d) % num;
            if (d <= num && !res.found && req[5'(cand)]) begin
                res.found = 1'b1;
                res.idx   = 5'(cand);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter: request levels in, grant/select/status out.
interface ram_port_arbiter_if #(
    parameter int NUM_PORTS   = 6,
    parameter int SelectWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) ();

    logic [NUM_PORTS-1:0]   req_i;
    logic [NUM_PORTS-1:0]   gnt_o;
    logic [SelectWidth-1:0] select_o;
    logic                   busy_o;
    logic                   timeout_o;

    modport master (
        output req_i,
        input  gnt_o, select_o, busy_o, timeout_o
    );

    modport slave (
        input  req_i,
        output gnt_o, select_o, busy_o, timeout_o
    );

endinterface

// File: rtl/ram_port_arbiter_rr_priority_pick.sv
// Combinational rotate-and-find-first picker; reusable by any round-robin arbiter.
module rr_priority_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 6,
    parameter int SEL_W     = 3
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [SEL_W-1:0]     last_i,
    output logic [SEL_W-1:0]     idx_o,
    output logic                 found_o
);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_PORTS'(req_i), 32'(last_i), NUM_PORTS);
        found_o = pick.found;
        idx_o   = SEL_W'(pick.idx);
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner arbiter for a shared single-port RAM with hold limit and turnaround cycle.
// Optional per-port grant statistics are enabled by defining RAM_ARB_STATS_EN.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 6,
    parameter int SelectWidth = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int MAX_HOLD    = 16,
    parameter int HoldWidth   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    ram_port_arbiter_if.slave   bus
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*STAT_WIDTH-1:0] grant_count_o
`endif
);

    localparam logic [HoldWidth-1:0]   HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HoldWidth'(MAX_HOLD - 1);
    localparam logic [SelectWidth-1:0] LAST_RESET = SelectWidth'(NUM_PORTS - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [SelectWidth-1:0] sel_q, sel_d;
    logic [SelectWidth-1:0] last_q, last_d;
    logic [HoldWidth-1:0]   hold_q, hold_d;
    logic                   tmo_q, tmo_d;

    logic [SelectWidth-1:0] pick_idx;
    logic                   pick_found;
    logic                   owner_req;
    logic                   grant_entry;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SelectWidth)
    ) u_pick (
        .req_i   (bus.req_i),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= LAST_RESET;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        last_d      = last_q;
        hold_d      = hold_q;
        tmo_d       = 1'b0;
        grant_entry = 1'b0;
        owner_req   = bus.req_i[sel_q];

        case (state_q)
            IDLE, TURN: begin
                // Arbitration from TURN sees last_q already pointing at the previous owner.
                if (pick_found) begin
                    state_d     = GRANT;
                    gnt_d       = NUM_PORTS'(1) << pick_idx;
                    sel_d       = pick_idx;
                    hold_d      = '0;
                    grant_entry = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                hold_d = hold_q + 1'b1;
                if (!owner_req) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    last_d  = sel_q;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                    state_d = TURN;
                    gnt_d   = '0;
                    last_d  = sel_q;
                    tmo_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.select_o  = sel_q;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.timeout_o = tmo_q;

`ifdef RAM_ARB_STATS_EN
    logic [NUM_PORTS*STAT_WIDTH-1:0] stat_q;

    // Saturating per-port count of ownership starts; cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stat_q <= '0;
        end else if (grant_entry) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (SelectWidth'(p) == pick_idx &&
                    stat_q[p*STAT_WIDTH +: STAT_WIDTH] != {STAT_WIDTH{1'b1}}) begin
                    stat_q[p*STAT_WIDTH +: STAT_WIDTH] <=
                        stat_q[p*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
                end
            end
        end
    end

    assign grant_count_o = stat_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_ram_port_arbiter;

    localparam int NP = 6;
    localparam int MH = 4;
    localparam int SW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ram_port_arbiter_if #(.NUM_PORTS(NP), .SelectWidth(SW)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic [NP*16-1:0] gcnt;
`endif

    ram_port_arbiter #(
        .NUM_PORTS (NP),
        .MAX_HOLD  (MH)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
`ifdef RAM_ARB_STATS_EN
        ,
        .grant_count_o (gcnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: who owns the RAM, for how many cycles, and whether a turnaround is pending.
    int m_owner;
    int m_cycles;
    int m_last;
    int m_sel;
    bit m_turn;
    bit m_tmo;

    function automatic int pick(input logic [NP-1:0] req, input int last);
        for (int d = 1; d <= NP; d++)
            if (req[(last + d) % NP]) return (last + d) % NP;
        return -1;
    endfunction

    function automatic logic [NP-1:0] m_gnt();
        logic [NP-1:0] v;
        v = '0;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    function automatic logic m_busy();
        return (m_owner >= 0) || m_turn;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_cycles = 0;
        m_last   = NP - 1;
        m_sel    = 0;
        m_turn   = 1'b0;
        m_tmo    = 1'b0;
    endtask

    task automatic model_step(input logic [NP-1:0] req);
        int w;
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            m_cycles++;
            if (!req[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_turn  = 1'b1;
            end else if (MH != 0 && m_cycles == MH) begin
                m_last  = m_owner;
                m_owner = -1;
                m_turn  = 1'b1;
                m_tmo   = 1'b1;
            end
        end else begin
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner  = w;
                m_cycles = 0;
                m_sel    = w;
            end
            m_turn = 1'b0;
        end
    endtask

    // Drive one request pattern across one rising edge and land on the following falling edge.
    task automatic tick(input logic [NP-1:0] req);
        bus.req_i = req;
        @(posedge clk);
        model_step(req);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        bus.req_i = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_i = '0;
        rst_n     = 1'b0;
        model_reset();
        #22;
        n_cmp++; if (bus.gnt_o !== '0) begin n_bad++; $display("FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
        n_cmp++; if (bus.select_o !== '0) begin n_bad++; $display("FAIL reset_sel: got %0d expected 0", bus.select_o); end
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        n_cmp++; if (bus.timeout_o !== 1'b0) begin n_bad++; $display("FAIL reset_tmo: got %b expected 0", bus.timeout_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_req();
        tick('0);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b expected 0", bus.busy_o); end
        tick(6'b000100);
        n_cmp++; if (bus.gnt_o !== 6'b000100) begin n_bad++; $display("FAIL single_gnt: got %b expected 000100", bus.gnt_o); end
        n_cmp++; if (bus.select_o !== 3'd2) begin n_bad++; $display("FAIL single_sel: got %0d expected 2", bus.select_o); end
        n_cmp++; if (bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b expected 1", bus.busy_o); end
        tick('0);
        n_cmp++; if (bus.gnt_o !== '0 || bus.busy_o !== 1'b1) begin n_bad++; $display("FAIL single_turn: got gnt %b busy %b expected 000000/1", bus.gnt_o, bus.busy_o); end
        tick('0);
        n_cmp++; if (bus.busy_o !== 1'b0 || bus.select_o !== 3'd2) begin n_bad++; $display("FAIL single_idle: got busy %b sel %0d expected 0/2", bus.busy_o, bus.select_o); end
    endtask

    task automatic test_release_handoff();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick(6'b100001);
            n_cmp++; if (bus.gnt_o !== 6'b000001) begin n_bad++; $display("FAIL handoff_own0 cyc%0d: got %b expected 000001", i, bus.gnt_o); end
        end
        tick(6'b100000);
        n_cmp++; if (bus.gnt_o !== '0 || bus.select_o !== 3'd0 || bus.busy_o !== 1'b1) begin
            n_bad++; $display("FAIL handoff_turn: got gnt %b sel %0d busy %b expected 000000/0/1", bus.gnt_o, bus.select_o, bus.busy_o);
        end
        tick(6'b100000);
        n_cmp++; if (bus.gnt_o !== 6'b100000 || bus.select_o !== 3'd5) begin
            n_bad++; $display("FAIL handoff_next: got gnt %b sel %0d expected 100000/5", bus.gnt_o, bus.select_o);
        end
        tick('0);
        tick('0);
    endtask

    task automatic test_timeout_single();
        bit exp_g;
        apply_reset();
        for (int k = 1; k <= 20; k++) begin
            tick(6'b001000);
            exp_g = ((k - 1) % 5) != 4;
            n_cmp++; if (bus.gnt_o !== (exp_g ? 6'b001000 : 6'b000000)) begin
                n_bad++; $display("FAIL timeout_gnt k%0d: got %b expected granted=%0d", k, bus.gnt_o, exp_g);
            end
            n_cmp++; if (bus.timeout_o !== !exp_g) begin
                n_bad++; $display("FAIL timeout_pulse k%0d: got %b expected %b", k, bus.timeout_o, !exp_g);
            end
        end
        tick('0);
        tick('0);
    endtask

    task automatic test_all_rotate();
        int seq[$];
        logic [NP-1:0] prev;
        apply_reset();
        prev = '0;
        for (int k = 0; k < 40; k++) begin
            tick('1);
            n_cmp++; if (!$onehot0(bus.gnt_o)) begin n_bad++; $display("FAIL rotate_onehot k%0d: got %b expected zero or one-hot", k, bus.gnt_o); end
            if (bus.gnt_o != '0 && prev == '0) seq.push_back(int'(bus.select_o));
            prev = bus.gnt_o;
        end
        n_cmp++; if (seq.size() < 7) begin n_bad++; $display("FAIL rotate_count: got %0d grants expected >= 7", seq.size()); end
        for (int i = 0; i < 7 && i < seq.size(); i++) begin
            n_cmp++; if (seq[i] != i % NP) begin n_bad++; $display("FAIL rotate_order #%0d: got %0d expected %0d", i, seq[i], i % NP); end
        end
        tick('0);
        tick('0);
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(6'b010000);
        tick(6'b010000);
        n_cmp++; if (bus.gnt_o !== 6'b010000) begin n_bad++; $display("FAIL areset_owner: got %b expected 010000", bus.gnt_o); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (bus.gnt_o !== '0 || bus.select_o !== '0 || bus.busy_o !== 1'b0) begin
            n_bad++; $display("FAIL areset_immediate: got gnt %b sel %0d busy %b expected 000000/0/0", bus.gnt_o, bus.select_o, bus.busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick(6'b010001);
        n_cmp++; if (bus.gnt_o !== 6'b000001 || bus.select_o !== 3'd0) begin
            n_bad++; $display("FAIL areset_first: got gnt %b sel %0d expected 000001/0", bus.gnt_o, bus.select_o);
        end
        tick('0);
        tick('0);
    endtask

    task automatic test_random();
        logic [NP-1:0] req;
        apply_reset();
        req = '0;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < NP; b++)
                if ($urandom_range(4, 0) == 0) req[b] = ~req[b];
            tick(req);
            n_cmp++; if (bus.gnt_o !== m_gnt()) begin n_bad++; $display("FAIL rand_gnt k%0d: got %b expected %b", k, bus.gnt_o, m_gnt()); end
            n_cmp++; if (int'(bus.select_o) != m_sel) begin n_bad++; $display("FAIL rand_sel k%0d: got %0d expected %0d", k, bus.select_o, m_sel); end
            n_cmp++; if (bus.busy_o !== m_busy()) begin n_bad++; $display("FAIL rand_busy k%0d: got %b expected %b", k, bus.busy_o, m_busy()); end
            n_cmp++; if (bus.timeout_o !== m_tmo) begin n_bad++; $display("FAIL rand_tmo k%0d: got %b expected %b", k, bus.timeout_o, m_tmo); end
            if (bus.gnt_o != '0) begin
                n_cmp++; if (bus.gnt_o[bus.select_o] !== 1'b1) begin n_bad++; $display("FAIL rand_inv k%0d: got gnt %b sel %0d expected gnt[sel]=1", k, bus.gnt_o, bus.select_o); end
            end
        end
        tick('0);
        tick('0);
    endtask

`ifdef RAM_ARB_STATS_EN
    task automatic test_stats();
        logic [NP*16-1:0] preset;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick(6'b000010);
            tick(6'b000010);
            tick('0);
            tick('0);
        end
        n_cmp++; if (gcnt[31:16] !== 16'd3) begin n_bad++; $display("FAIL stats_count: got %0d expected 3", gcnt[31:16]); end
        n_cmp++; if (gcnt[15:0] !== 16'd0) begin n_bad++; $display("FAIL stats_other: got %0d expected 0", gcnt[15:0]); end
        preset = '0;
        preset[31:16] = 16'hFFFF;
        force dut.stat_q = preset;
        #1;
        release dut.stat_q;
        @(negedge clk);
        tick(6'b000010);
        tick('0);
        tick('0);
        n_cmp++; if (gcnt[31:16] !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat: got %h expected ffff", gcnt[31:16]); end
    endtask
`endif

    initial begin
        bus.req_i = '0;
        test_reset();
        test_single_req();
        test_release_handoff();
        test_timeout_single();
        test_all_rotate();
        test_async_reset();
        test_random();
`ifdef RAM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Round-robin arbiter that shares one single-port RAM between NUM_PORTS requesters.
- Drives the select input of the existing RAM input mux and gives each requester a one-hot grant.
- Holds ownership while the owner keeps requesting, with an optional hold limit for fairness.
- Inserts one turnaround cycle between owners so in-flight read data returns to the previous owner before select changes.

Parameters:
- NUM_PORTS, 6, number of requesters (>= 1)
- SelectWidth, (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1, width of select_o
- MAX_HOLD, 16, max consecutive grant cycles per ownership; 0 = unlimited
- HoldWidth, $clog2(MAX_HOLD+1), hold counter width (min 1)

Ports:
- clk_i  input  1  clock
- reset_ni  input  1  asynchronous active-low reset
- req_i  input  NUM_PORTS  per-port request level; the requester holds it until granted and for as long as it wants ownership
- gnt_o  output  NUM_PORTS  one-hot grant (registered)
- select_o  output  SelectWidth  owner index for the RAM mux select (registered)
- busy_o  output  1  high when the state is not IDLE
- timeout_o  output  1  one-cycle pulse when ownership is revoked by MAX_HOLD

Behaviour:
- Clocking and reset: one clock, clk_i. reset_ni is asynchronous, active-low.
- Reset values:
  - state = IDLE; gnt_o = 0; select_o = 0; busy_o = 0; timeout_o = 0
  - hold_cnt = 0
  - last_owner = NUM_PORTS-1, so port 0 has first priority
- FSM states: IDLE, GRANT, TURN.
- Arbitration function (combinational):
  - Search starts at index last_owner+1 and wraps modulo NUM_PORTS.
  - The first set req_i bit wins.
- IDLE:
  - If req_i != 0 at edge t, then from t+1: state = GRANT, gnt_o = onehot(winner), select_o = winner, hold_cnt = 0.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - hold_cnt increments each cycle.
  - Release: req_i[owner] == 0 at edge t. Next cycle: state = TURN, gnt_o = 0, last_owner = owner.
  - Timeout: MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and req_i[owner] still 1. Next cycle: state = TURN, gnt_o = 0, timeout_o = 1 for exactly one cycle, last_owner = owner.
  - Max grant length is therefore MAX_HOLD cycles.
  - If release and timeout coincide, release wins: no timeout_o pulse.
- TURN:
  - Lasts exactly one cycle; gnt_o = 0 and select_o holds the previous owner.
  - If req_i != 0, arbitrate as in IDLE and go directly to GRANT with the new winner.
  - Otherwise go to IDLE.
  - Between consecutive owners gnt_o is low for exactly 1 cycle.
- A revoked owner that still requests gets lowest priority. If it is the only requester it is regranted after TURN.
- Requests from non-owners are never latched. A request dropped before being granted is forgotten.
- select_o changes only on entry to GRANT. In IDLE it holds its last value.
- busy_o is 1 in GRANT and TURN.
- Invariants: gnt_o is always zero or one-hot; gnt_o[select_o] == gnt_o != 0 whenever state == GRANT.
- reset_ni low mid-operation: all outputs and state return to reset values immediately (asynchronous), with no turnaround.
- NUM_PORTS == 1: select_o stays 0; the single port alternates GRANT/TURN under timeout.

Optional Feature:
- Macro: RAM_ARB_STATS_EN
- Defined:
  - Adds output grant_count_o, width NUM_PORTS*16.
  - Per-port 16-bit counter increments on each entry to GRANT for that port and saturates at 16'hFFFF.
  - Counters clear on reset only.
- Undefined: no port, no counters, no logic.

Decomposition:
- Package ram_arb_pkg:
  - state enum typedef (IDLE, GRANT, TURN)
  - STAT_WIDTH = 16 constant
  - rr_pick function (request vector + last owner -> index + found flag)
- One sub-module, rr_priority_pick: combinational rotate-and-find-first. It is reusable by other arbiters in the design.

Test Plan:
- Reset, then req_i = 6'b000100 at cycle 2 -> gnt_o = 6'b000100, select_o = 2 at cycle 3; busy_o = 1.
- req_i = 6'b100001 held, owner 0 drops req after 3 grant cycles -> one TURN cycle with gnt_o = 0 and select_o = 0, then gnt_o = 6'b100000, select_o = 5.
- MAX_HOLD = 4, port 3 requests continuously alone -> GRANT for 4 cycles, timeout_o pulse with 1 TURN cycle, then regrant to port 3; the pattern repeats.
- All six ports request continuously, MAX_HOLD = 4 -> grants rotate in order 0,1,2,3,4,5,0; no port skipped; one-hot checked every cycle.
- reset_ni asserted mid-GRANT (owner 4) -> gnt_o = 0, select_o = 0, busy_o = 0 immediately; after release, port 0 wins first over simultaneous 6'b010001.
- RAM_ARB_STATS_EN: port 1 granted 3 times -> grant_count_o[31:16] = 3; forced counter value 16'hFFFF stays 16'hFFFF on further grants.
